// File: rtl/riscv_core_dpath_dmem_resp_queue_pkg.sv
// riscv_dmem_pkg: load-mode encodings shared by the dmem response path and M-stage mux
package riscv_dmem_pkg;
   typedef enum logic [2:0] {
      MODE_FULL = 3'd0,
      MODE_LB   = 3'd1,
      MODE_LBU  = 3'd2,
      MODE_LH   = 3'd3,
      MODE_LHU  = 3'd4,
      MODE_LW   = 3'd5,
      MODE_LWU  = 3'd6,
      MODE_RSVD = 3'd7
   } mode_e;
endpackage

// File: rtl/riscv_core_dpath_dmem_resp_queue_if.sv
// riscv_core_dpath_dmem_resp_queue_if: dmem response enqueue side and M-stage dequeue side
interface riscv_core_dpath_dmem_resp_queue_if #(parameter int DATA_W = 32);
   localparam int OW = $clog2(DATA_W / 8);
   logic              enq_val;
   logic              enq_rdy;
   logic [DATA_W-1:0] enq_data;
   logic [2:0]        enq_mode;
   logic [OW-1:0]     enq_byte_off;
   logic              deq_val;
   logic              deq_rdy;
   logic [DATA_W-1:0] deq_data;
   modport master (output enq_val, enq_data, enq_mode, enq_byte_off, deq_rdy,
                   input  enq_rdy, deq_val, deq_data);
   modport slave  (input  enq_val, enq_data, enq_mode, enq_byte_off, deq_rdy,
                   output enq_rdy, deq_val, deq_data);
endinterface

// File: rtl/riscv_core_dpath_subword_adjust.sv
// riscv_core_dpath_subword_adjust: byte/half/word extraction with sign or zero extension
module riscv_core_dpath_subword_adjust
   import riscv_dmem_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  logic [DATA_W-1:0]              data,
   input  logic [2:0]                     mode,
   input  logic [$clog2(DATA_W/8)-1:0]    byte_off,
   output logic [DATA_W-1:0]              adj
);
   localparam int OW = $clog2(DATA_W / 8);
   localparam bit WIDE = DATA_W == 64;
   localparam logic [OW+2:0] H_MASK = ~(OW+3)'(8);
   localparam logic [OW+2:0] W_MASK = (OW+3)'(WIDE ? 32 : 0);
   logic [OW+2:0]     sb;
   logic [DATA_W-1:0] b, h, w;
   // word modes use the low half of w; on a 32-bit path they fall through to full data
   always_comb begin
      sb  = {byte_off, 3'b000};
      b   = data >> sb;
      h   = data >> (sb & H_MASK);
      w   = data >> (sb & W_MASK);
      adj = mode == MODE_LB  ? {{(DATA_W-8){b[7]}}, b[7:0]} :
            mode == MODE_LBU ? {{(DATA_W-8){1'b0}}, b[7:0]} :
            mode == MODE_LH  ? {{(DATA_W-16){h[15]}}, h[15:0]} :
            mode == MODE_LHU ? {{(DATA_W-16){1'b0}}, h[15:0]} :
            WIDE && mode == MODE_LW  ? {{(DATA_W/2){w[31]}}, w[DATA_W/2-1:0]} :
            WIDE && mode == MODE_LWU ? {{(DATA_W/2){1'b0}}, w[DATA_W/2-1:0]} :
            data;
   end
endmodule

// File: rtl/riscv_core_dpath_dmem_resp_queue.sv
// riscv_core_dpath_dmem_resp_queue: DEPTH-entry dmem response FIFO with subword adjust and optional bypass
module riscv_core_dpath_dmem_resp_queue
   import riscv_dmem_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 2,
   parameter int BYPASS = 1
) (
   input  logic                         clk,
   input  logic                         reset_n,
   input  logic                         flush,
   riscv_core_dpath_dmem_resp_queue_if.slave q,
   output logic [$clog2(DEPTH+1)-1:0]   count,
   output logic                         full,
   output logic                         empty
);
   localparam int CW = $clog2(DEPTH + 1);
   localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
   logic [DATA_W-1:0] mem [DEPTH];
   logic [DATA_W-1:0] adj;
   logic [PW-1:0]     head, tail;
   logic              bypass, enq_fire, deq_fire;
   riscv_core_dpath_subword_adjust #(.DATA_W(DATA_W)) u_adj (
      .data     (q.enq_data),
      .mode     (q.enq_mode),
      .byte_off (q.enq_byte_off),
      .adj      (adj)
   );
   always_comb begin
      full       = count == CW'(DEPTH);
      empty      = count == '0;
      bypass     = BYPASS != 0 && empty && q.enq_val && q.deq_rdy && !flush;
      q.enq_rdy  = !full && !flush;
      q.deq_val  = (!empty && !flush) || bypass;
      q.deq_data = bypass ? adj : mem[head];
      enq_fire   = q.enq_val && q.enq_rdy && !bypass;
      deq_fire   = !empty && !flush && q.deq_rdy;
   end
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else if (flush) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         if (enq_fire) tail <= tail == PW'(DEPTH - 1) ? '0 : tail + PW'(1);
         if (deq_fire) head <= head == PW'(DEPTH - 1) ? '0 : head + PW'(1);
         count <= count + CW'(enq_fire) - CW'(deq_fire);
      end
   end
   always_ff @(posedge clk) begin
      if (enq_fire) mem[tail] <= adj;
   end
   a_no_overflow: assert property (@(posedge clk) disable iff (!reset_n) count <= CW'(DEPTH));
endmodule
